// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: decodes start/stop, lap and clear pulses and drives the
// BCD counter chain enable, clear, lap-latch load and display-hold select.
module stopwatch_ctrl #(
  parameter int unsigned DIV = 1000000,
  localparam int unsigned PW = $clog2(DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_p,
  input  logic       lap_p,
  input  logic       clr_p,
  input  logic       chain_ovf,
  output logic       cnt_enb,
  output logic       cnt_clr,
  output logic       lap_load,
  output logic       disp_hold,
  output logic       running,
  output logic       ovf_flag,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_e;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          lap_load_q, lap_load_d;
  logic          disp_hold_q, disp_hold_d;
  logic          running_q, running_d;
  logic          ovf_q, ovf_d;

  logic clr_sel, ss_sel, lap_sel, ovf_evt;

  // Button priority clr > ss > lap; losers in the same cycle are dropped.
  assign clr_sel = clr_p;
  assign ss_sel  = ss_p & ~clr_p;
  assign lap_sel = lap_p & ~clr_p & ~ss_p;

  assign cnt_enb = running_q && (presc_q == PRESC_LAST);
  assign ovf_evt = cnt_enb & chain_ovf;

  // State and registered outputs; reset also clears the digit chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      cnt_clr_q   <= 1'b1;
      lap_load_q  <= 1'b0;
      disp_hold_q <= 1'b0;
      running_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      cnt_clr_q   <= cnt_clr_d;
      lap_load_q  <= lap_load_d;
      disp_hold_q <= disp_hold_d;
      running_q   <= running_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next-state logic; a chain overflow pre-empts any button in the same cycle.
  always_comb begin
    state_d = state_q;
    if (ovf_evt) begin
      state_d = S_PAUSE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (ss_sel) state_d = S_RUN;
        S_RUN: begin
          if (ss_sel)       state_d = S_PAUSE;
          else if (lap_sel) state_d = S_LAP;
        end
        S_LAP: begin
          if (ss_sel)       state_d = S_PAUSE;
          else if (lap_sel) state_d = S_RUN;
        end
        S_PAUSE: begin
          if (clr_sel)     state_d = S_IDLE;
          else if (ss_sel) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values.
  always_comb begin
    cnt_clr_d   = 1'b0;
    lap_load_d  = 1'b0;
    presc_d     = presc_q;
    ovf_d       = ovf_q;
    disp_hold_d = (state_d == S_LAP);
    running_d   = (state_d == S_RUN) || (state_d == S_LAP);

    if (clr_sel && ((state_q == S_IDLE) || (state_q == S_PAUSE))) begin
      cnt_clr_d = 1'b1;
    end
    if (lap_sel && (state_q == S_RUN) && !ovf_evt) begin
      lap_load_d = 1'b1;
    end

    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (cnt_clr_d) begin
      ovf_d = 1'b0;
    end

    // Prescaler holds while paused so a resume finishes the partial tick.
    if (cnt_clr_d) begin
      presc_d = '0;
    end else if (running_q) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    end
  end

  assign cnt_clr   = cnt_clr_q;
  assign lap_load  = lap_load_q;
  assign disp_hold = disp_hold_q;
  assign running   = running_q;
  assign ovf_flag  = ovf_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a behavioural model predicts each cycle's
// outputs, a monitor compares them against the DUT one cycle later.
module tb_stopwatch_ctrl;

  localparam int unsigned DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;

  typedef struct packed {
    logic [1:0] st;
    logic       run;
    logic       hold;
    logic       clr;
    logic       ld;
    logic       ovf;
    logic       enb;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0, ss_p = 1'b0, lap_p = 1'b0, clr_p = 1'b0, chain_ovf = 1'b0;
  logic cnt_enb, cnt_clr, lap_load, disp_hold, running, ovf_flag;
  logic [1:0] state;

  stopwatch_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .ss_p(ss_p), .lap_p(lap_p), .clr_p(clr_p),
    .chain_ovf(chain_ovf), .cnt_enb(cnt_enb), .cnt_clr(cnt_clr),
    .lap_load(lap_load), .disp_hold(disp_hold), .running(running),
    .ovf_flag(ovf_flag), .state(state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  exp_t sb_q[$];

  // Reference model: mode, running cycles since last clear, sticky overflow.
  int m_mode = M_IDLE;
  int m_cyc  = 0;
  bit m_ovf  = 1'b0;

  function automatic bit m_running(int mode);
    return (mode == M_RUN) || (mode == M_LAP);
  endfunction

  // An enable fires on every DIV-th running cycle counted from the last clear.
  function automatic bit m_enb_now();
    return m_running(m_mode) && (((m_cyc + 1) % DIV) == 0);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue the post-edge outputs.
  task automatic step(input bit r, input bit s, input bit l, input bit c, input bit o);
    bit enb, exp_clr, exp_ld;
    exp_t e;
    @(negedge clk);
    rst = r; ss_p = s; lap_p = l; clr_p = c; chain_ovf = o;
    enb = m_enb_now();
    exp_clr = 1'b0;
    exp_ld  = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_cyc = 0; m_ovf = 1'b0; exp_clr = 1'b1;
    end else begin
      if (m_running(m_mode)) m_cyc++;
      if (enb && o) begin
        m_mode = M_PAUSE; m_ovf = 1'b1;
      end else if (c) begin
        if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
          m_mode = M_IDLE; m_cyc = 0; m_ovf = 1'b0; exp_clr = 1'b1;
        end
      end else if (s) begin
        m_mode = (m_mode == M_RUN || m_mode == M_LAP) ? M_PAUSE : M_RUN;
      end else if (l) begin
        if (m_mode == M_RUN) begin
          m_mode = M_LAP; exp_ld = 1'b1;
        end else if (m_mode == M_LAP) begin
          m_mode = M_RUN;
        end
      end
    end
    e.st   = 2'(m_mode);
    e.run  = m_running(m_mode);
    e.hold = (m_mode == M_LAP);
    e.clr  = exp_clr;
    e.ld   = exp_ld;
    e.ovf  = m_ovf;
    e.enb  = m_enb_now();
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("state",     int'(state),     int'(e.st));
        chk("running",   int'(running),   int'(e.run));
        chk("disp_hold", int'(disp_hold), int'(e.hold));
        chk("cnt_clr",   int'(cnt_clr),   int'(e.clr));
        chk("lap_load",  int'(lap_load),  int'(e.ld));
        chk("ovf_flag",  int'(ovf_flag),  int'(e.ovf));
        chk("cnt_enb",   int'(cnt_enb),   int'(e.enb));
      end
    end
  end

  initial begin
    int guard;
    int r;
    // Start and steady counting.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    idle(12);
    // Pause mid-tick, hold, resume.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    idle(6);
    step(0, 1, 0, 0, 0);
    idle(10);
    step(0, 1, 0, 0, 0);
    idle(4);
    // Lap in and out.
    step(0, 0, 1, 0, 0);
    idle(3);
    step(0, 0, 1, 0, 0);
    idle(3);
    // Clear and start together from PAUSE, then clear while running.
    step(0, 1, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 1, 0);
    idle(2);
    step(0, 1, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 0);
    idle(2);
    // Overflow coincident with an enable and a start/stop press.
    guard = 0;
    while (!m_enb_now() && guard < 2 * DIV) begin
      step(0, 0, 0, 0, 0);
      guard++;
    end
    chk("ovf_setup_enb", int'(m_enb_now()), 1);
    step(0, 1, 0, 0, 1);
    idle(3);
    step(0, 1, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(2);
    // Reset while in LAP.
    step(0, 1, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0);
    idle(3);
    // Randomised single-button traffic with random chain carries.
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 19));
      step($urandom_range(0, 199) == 0, r == 0 || r == 1, r == 2, r == 3,
           $urandom_range(0, 2) == 0);
    end
    step(0, 0, 0, 0, 0);
    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
